// File: rtl/pipe_ctrl.sv
// Pipeline control for MiniMIPS32: merges stall requests and sequences exception/ERET flushes.
// Optional PIPE_CTRL_PERF_EN adds stall_cycles/flush_count counters.
`ifndef EXC_CODE_WIDTH
`define EXC_CODE_WIDTH 5
`endif
`ifndef EC_None
`define EC_None 5'h10
`endif

module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stallreq_if,
  input  logic                       stallreq_id,
  input  logic                       stallreq_ex,
  input  logic                       stallreq_mem,
  input  logic                       exc_valid,
  input  logic [`EXC_CODE_WIDTH-1:0] exc_code_i,
  input  logic                       exc_is_eret,
  input  logic [31:0]                cp0_epc,
  output logic [5:0]                 stall,
  output logic                       flush,
  output logic [31:0]                new_pc,
  output logic [`EXC_CODE_WIDTH-1:0] exc_code_o,
  output logic                       ctrl_busy
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]                stall_cycles,
  output logic [31:0]                flush_count
`endif
);

  typedef enum logic [1:0] {RUN, HOLD, DRAIN} state_t;

  state_t                     state, state_nxt;
  logic [`EXC_CODE_WIDTH-1:0] pend_code;
  logic                       pend_eret;
  logic [31:0]                pend_epc;
  logic                       latch;

  logic [5:0]                 stall_c;
  logic                       flush_c;
  logic [31:0]                new_pc_c;
  logic [`EXC_CODE_WIDTH-1:0] code_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      pend_code <= '0;
      pend_eret <= 1'b0;
      pend_epc  <= '0;
    end else begin
      state <= state_nxt;
      if (latch) begin
        pend_code <= exc_code_i;
        pend_eret <= exc_is_eret;
        pend_epc  <= cp0_epc;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    stall_c   = 6'b000000;
    flush_c   = 1'b0;
    new_pc_c  = 32'h0;
    code_c    = `EC_None;
    latch     = 1'b0;
    case (state)
      RUN: begin
        if (exc_valid) begin
          if (stallreq_mem) begin
            // Data bus mid-transfer: freeze up to MEM and retire the event later.
            stall_c   = 6'b011111;
            latch     = 1'b1;
            state_nxt = HOLD;
          end else begin
            flush_c   = 1'b1;
            new_pc_c  = exc_is_eret ? cp0_epc : EXC_VECTOR;
            code_c    = exc_code_i;
            state_nxt = stallreq_if ? DRAIN : RUN;
          end
        end else if (stallreq_mem) begin
          stall_c = 6'b011111;
        end else if (stallreq_ex) begin
          stall_c = 6'b001111;
        end else if (stallreq_id) begin
          stall_c = 6'b000111;
        end else if (stallreq_if) begin
          stall_c = 6'b000011;
        end
      end
      HOLD: begin
        if (stallreq_mem) begin
          stall_c = 6'b011111;
        end else begin
          flush_c   = 1'b1;
          new_pc_c  = pend_eret ? pend_epc : EXC_VECTOR;
          code_c    = pend_code;
          state_nxt = stallreq_if ? DRAIN : RUN;
        end
      end
      DRAIN: begin
        // Stale fetch still in flight; hold PC/IF_ID until it completes.
        if (stallreq_if) begin
          stall_c = 6'b000011;
        end else begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // Outputs read as idle for the whole time reset is asserted.
  assign stall      = rst ? stall_c  : 6'b000000;
  assign flush      = rst ? flush_c  : 1'b0;
  assign new_pc     = rst ? new_pc_c : 32'h0;
  assign exc_code_o = rst ? code_c   : `EC_None;
  assign ctrl_busy  = rst && (state != RUN);

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall[0]) stall_cycles <= stall_cycles + 32'd1;
      if (flush)    flush_count  <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl.
`ifndef EXC_CODE_WIDTH
`define EXC_CODE_WIDTH 5
`endif
`ifndef EC_None
`define EC_None 5'h10
`endif

module tb_pipe_ctrl;
  logic                       clk;
  logic                       rst;
  logic                       stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic                       exc_valid;
  logic [`EXC_CODE_WIDTH-1:0] exc_code_i;
  logic                       exc_is_eret;
  logic [31:0]                cp0_epc;
  logic [5:0]                 stall;
  logic                       flush;
  logic [31:0]                new_pc;
  logic [`EXC_CODE_WIDTH-1:0] exc_code_o;
  logic                       ctrl_busy;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0]                stall_cycles, flush_count;
`endif

  int checks = 0;
  int errors = 0;

  pipe_ctrl dut (
    .clk(clk), .rst(rst),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .exc_valid(exc_valid), .exc_code_i(exc_code_i),
    .exc_is_eret(exc_is_eret), .cp0_epc(cp0_epc),
    .stall(stall), .flush(flush), .new_pc(new_pc),
    .exc_code_o(exc_code_o), .ctrl_busy(ctrl_busy)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs are then changed and
  // outputs sampled a couple of ns later, well away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
    exc_valid = 0; exc_code_i = '0; exc_is_eret = 0; cp0_epc = '0;
  endtask

  task automatic test_reset();
    rst = 0;
    stallreq_mem = 1; stallreq_if = 1; exc_valid = 1; exc_code_i = 5'h04;
    exc_is_eret = 0; cp0_epc = 32'h1234_5678;
    #2;
    checks++;
    if (stall !== 6'b0 || flush !== 1'b0 || new_pc !== 32'h0 ||
        exc_code_o !== `EC_None || ctrl_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got stall=%b flush=%b pc=%h code=%h busy=%b want 0/0/0/%h/0",
               stall, flush, new_pc, exc_code_o, ctrl_busy, `EC_None);
    end
    idle_inputs();
    tick();
    rst = 1;
    tick();
    #1;
    checks++;
    if (stall !== 6'b0 || flush !== 1'b0 || ctrl_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got stall=%b flush=%b busy=%b want 0/0/0", stall, flush, ctrl_busy);
    end
  endtask

  task automatic test_stall_priority();
    for (int i = 0; i < 3; i++) begin
      stallreq_ex = 1; stallreq_id = 1;
      #2;
      checks++;
      if (stall !== 6'b001111 || flush !== 1'b0) begin
        errors++;
        $display("FAIL ex_id_stall cyc=%0d got stall=%b flush=%b want 001111/0", i, stall, flush);
      end
      tick();
    end
    stallreq_ex = 0; stallreq_id = 0;
    #2;
    checks++;
    if (stall !== 6'b000000 || flush !== 1'b0) begin
      errors++;
      $display("FAIL stall_release got stall=%b flush=%b want 000000/0", stall, flush);
    end
    tick();
    stallreq_mem = 1; stallreq_if = 1; stallreq_ex = 1;
    #2;
    checks++;
    if (stall !== 6'b011111) begin
      errors++;
      $display("FAIL mem_priority got %b want 011111", stall);
    end
    tick();
    stallreq_mem = 0; stallreq_ex = 0; stallreq_id = 1; stallreq_if = 1;
    #2;
    checks++;
    if (stall !== 6'b000111) begin
      errors++;
      $display("FAIL id_priority got %b want 000111", stall);
    end
    tick();
    stallreq_id = 0;
    #2;
    checks++;
    if (stall !== 6'b000011) begin
      errors++;
      $display("FAIL if_only got %b want 000011", stall);
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_exception();
    // Exception dominates id/ex requests.
    exc_valid = 1; exc_is_eret = 0; exc_code_i = 5'h0c;
    cp0_epc = 32'hDEAD_BEEF; stallreq_ex = 1; stallreq_id = 1;
    #2;
    checks++;
    if (flush !== 1'b1 || new_pc !== 32'hBFC0_0380 || stall !== 6'b0 || exc_code_o !== 5'h0c) begin
      errors++;
      $display("FAIL exc_flush got flush=%b pc=%h stall=%b code=%h want 1/bfc00380/000000/0c",
               flush, new_pc, stall, exc_code_o);
    end
    tick();
    idle_inputs();
    #2;
    checks++;
    if (flush !== 1'b0 || ctrl_busy !== 1'b0 || exc_code_o !== `EC_None || new_pc !== 32'h0) begin
      errors++;
      $display("FAIL exc_after got flush=%b busy=%b code=%h pc=%h want 0/0/%h/0",
               flush, ctrl_busy, exc_code_o, new_pc, `EC_None);
    end
    tick();
  endtask

  task automatic test_eret_hold();
    exc_valid = 1; exc_is_eret = 1; exc_code_i = 5'h0e;
    cp0_epc = 32'h8000_1234; stallreq_mem = 1;
    #2;
    checks++;
    if (stall !== 6'b011111 || flush !== 1'b0) begin
      errors++;
      $display("FAIL eret_detect got stall=%b flush=%b want 011111/0", stall, flush);
    end
    tick();
    exc_valid = 0; exc_is_eret = 0; exc_code_i = 5'h01; cp0_epc = 32'h0;
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++;
      if (stall !== 6'b011111 || flush !== 1'b0 || ctrl_busy !== 1'b1) begin
        errors++;
        $display("FAIL eret_hold cyc=%0d got stall=%b flush=%b busy=%b want 011111/0/1",
                 i, stall, flush, ctrl_busy);
      end
      tick();
    end
    stallreq_mem = 0;
    #2;
    checks++;
    if (flush !== 1'b1 || new_pc !== 32'h8000_1234 || stall !== 6'b0 || exc_code_o !== 5'h0e) begin
      errors++;
      $display("FAIL eret_flush got flush=%b pc=%h stall=%b code=%h want 1/80001234/000000/0e",
               flush, new_pc, stall, exc_code_o);
    end
    tick();
    #2;
    checks++;
    if (flush !== 1'b0 || ctrl_busy !== 1'b0) begin
      errors++;
      $display("FAIL eret_after got flush=%b busy=%b want 0/0", flush, ctrl_busy);
    end
    tick();
  endtask

  task automatic test_drain();
    exc_valid = 1; exc_code_i = 5'h08; stallreq_if = 1;
    #2;
    checks++;
    if (flush !== 1'b1 || new_pc !== 32'hBFC0_0380 || stall !== 6'b0) begin
      errors++;
      $display("FAIL drain_flush got flush=%b pc=%h stall=%b want 1/bfc00380/000000", flush, new_pc, stall);
    end
    tick();
    exc_valid = 0;
    for (int i = 0; i < 2; i++) begin
      // Late exception pulse in DRAIN must be ignored.
      exc_valid = (i == 1);
      #2;
      checks++;
      if (stall !== 6'b000011 || flush !== 1'b0 || ctrl_busy !== 1'b1) begin
        errors++;
        $display("FAIL drain cyc=%0d got stall=%b flush=%b busy=%b want 000011/0/1",
                 i, stall, flush, ctrl_busy);
      end
      tick();
    end
    idle_inputs();
    #2;
    checks++;
    if (stall !== 6'b0 || flush !== 1'b0) begin
      errors++;
      $display("FAIL drain_end got stall=%b flush=%b want 000000/0", stall, flush);
    end
    tick();
    #2;
    checks++;
    if (ctrl_busy !== 1'b0 || stall !== 6'b0) begin
      errors++;
      $display("FAIL drain_idle got busy=%b stall=%b want 0/000000", ctrl_busy, stall);
    end
    tick();
  endtask

  task automatic test_reset_mid_hold();
    exc_valid = 1; exc_code_i = 5'h05; stallreq_mem = 1;
    tick();
    exc_valid = 0;
    #2;
    checks++;
    if (ctrl_busy !== 1'b1) begin
      errors++;
      $display("FAIL hold_entry got busy=%b want 1", ctrl_busy);
    end
    rst = 0;
    #1;
    checks++;
    if (stall !== 6'b0 || flush !== 1'b0 || new_pc !== 32'h0 ||
        exc_code_o !== `EC_None || ctrl_busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_hold got stall=%b flush=%b pc=%h code=%h busy=%b want all idle",
               stall, flush, new_pc, exc_code_o, ctrl_busy);
    end
    tick();
    stallreq_mem = 0;
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      #2;
      checks++;
      if (flush !== 1'b0 || ctrl_busy !== 1'b0 || exc_code_o !== `EC_None) begin
        errors++;
        $display("FAIL post_rst cyc=%0d got flush=%b busy=%b code=%h want 0/0/%h",
                 i, flush, ctrl_busy, exc_code_o, `EC_None);
      end
      tick();
    end
    idle_inputs();
  endtask

`ifdef PIPE_CTRL_PERF_EN
  task automatic test_perf();
    rst = 0;
    tick();
    rst = 1;
    tick();
    stallreq_ex = 1;
    repeat (5) tick();
    stallreq_ex = 0;
    tick();
    exc_valid = 1;
    tick();
    exc_valid = 0;
    tick();
    exc_valid = 1; exc_is_eret = 1; cp0_epc = 32'h0000_0040;
    tick();
    idle_inputs();
    tick();
    checks++;
    if (stall_cycles !== 32'd5 || flush_count !== 32'd2) begin
      errors++;
      $display("FAIL perf got stall_cycles=%0d flush_count=%0d want 5/2", stall_cycles, flush_count);
    end
  endtask
`endif

  initial begin
    idle_inputs();
    test_reset();
    test_stall_priority();
    test_exception();
    test_eret_hold();
    test_drain();
    test_reset_mid_hold();
`ifdef PIPE_CTRL_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end
endmodule
